store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 MemWrite  input  1  CPU store strobe for the current cycle.
REQ-005 DataAdr  input  32  CPU data byte address, used for both load and store.
REQ-006 WriteData  input  32  CPU store data.
REQ-007 ReadData  output  32  load data returned to the CPU, forwarded or from memory.
REQ-008 Stall  output  1  CPU SHALL hold its PC and store while high.
REQ-009 Empty  output  1  high when no store is buffered.
REQ-010 mem_req  output  1  drain request to data memory.
REQ-011 mem_adr  output  32  drain address, valid while mem_req is high.
REQ-012 mem_wdata  output  32  drain data, valid while mem_req is high.
REQ-013 mem_ack  input  1  memory accepts the presented drain write on this rising edge.
REQ-014 mem_radr  output  32  load address to memory, a combinational copy of DataAdr.
REQ-015 mem_rdata  input  32  combinational load data from memory.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH entries {word address [31:2], data [31:0]}, with head pointer, tail pointer and count 0..DEPTH.
REQ-017 Push: MemWrite=1 and count<DEPTH SHALL write {DataAdr[31:2], WriteData} at the tail on the edge, advance the tail and wrap DEPTH-1 -> 0.
REQ-018 Stall SHALL be combinational: MemWrite & (count==DEPTH). A pop on the same edge SHALL NOT clear Stall in that cycle.
REQ-019 A stalled store SHALL NOT be pushed; it is pushed on the first edge where Stall is low while MemWrite is held.
REQ-020 The drain FSM SHALL have two states. IDLE: mem_req=0. REQ: mem_req=1, with mem_adr={head addr,2'b00} and mem_wdata=head data.
REQ-021 IDLE -> REQ on any edge where count>0 at the start of the cycle. A store pushed into an empty buffer SHALL therefore raise mem_req exactly 1 cycle later.
REQ-022 In REQ, mem_ack=1 SHALL pop the head and advance the head with wrap. The next state is IDLE if count becomes 0, otherwise REQ presenting the next entry with no bubble.
REQ-023 In REQ with mem_ack=0, mem_adr and mem_wdata SHALL be held stable for any number of cycles.
REQ-024 mem_ack in IDLE SHALL be ignored.
REQ-025 On a simultaneous push and pop, count SHALL stay unchanged and both pointers SHALL advance.
REQ-026 Empty SHALL equal (count==0) and be registered-state derived.
REQ-027 Load forwarding: when MemWrite=0, ReadData SHALL be the data of the youngest valid entry whose address equals DataAdr[31:2], otherwise mem_rdata. This is combinational, with 0-cycle latency.
REQ-028 The entry being popped in the current cycle SHALL remain eligible for forwarding in that cycle.
REQ-029 Ordering: memory SHALL observe drain writes in exact push order, with no merging or dropping of same-address stores.
REQ-030 Only word stores are supported. DataAdr[1:0] SHALL be ignored for matching and forced to 0 on mem_adr.

Reset
REQ-031 reset=1 SHALL immediately, independent of clk, force count=0, head=tail=0, FSM=IDLE, mem_req=0, Empty=1 and Stall=0.
REQ-032 Reset mid-drain SHALL discard all buffered stores. The pending write is abandoned and memory SHALL tolerate mem_req dropping without ack.
REQ-033 Entry storage needs no reset. Invalid entries SHALL never forward or drain.
REQ-034 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-035 Single store: reset, then MemWrite=1, DataAdr=20, WriteData=2 for 1 cycle, mem_ack tied 1. Required: mem_req=1 with mem_adr=20 and mem_wdata=2 one cycle later, then Empty=1 one cycle after that.
REQ-036 Fill/stall: mem_ack=0, 5 consecutive stores to addresses 0,4,8,12,16. Required: Stall=0 for the first 4, Stall=1 on the 5th. Raising mem_ack for 1 edge drops Stall the following cycle and pushes address 16.
REQ-037 Forwarding: with mem_ack=0, store 0x11 then 0x22 to address 0x40, then load 0x40. Required: ReadData=0x22. A load of 0x44 SHALL return mem_rdata.
REQ-038 Order/wrap: push 10 stores with random mem_ack gaps. Required: memory sees all 10 in order, pointers wrap, and mem_adr/mem_wdata stay stable while ack is low.
REQ-039 Simultaneous push and pop at count=2. Required: count remains 2 and the new entry drains third.
REQ-040 Reset mid-drain with 3 entries and mem_ack=0. Required: mem_req=0 and Empty=1 immediately; nothing drains after reset release.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order word store buffer with drain FSM and youngest-match load forwarding
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Empty,
  output logic        mem_req,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [31:0] mem_radr,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [29:0] adr_q [DEPTH];
  logic [31:0] dat_q [DEPTH];
  logic [AW-1:0] head, tail, idx;
  logic [CW-1:0] count, count_next;
  logic push, pop, hit;
  logic [31:0] fwd_data;
  assign Stall      = MemWrite & (count == CW'(DEPTH));
  assign push       = MemWrite & (count != CW'(DEPTH));
  assign pop        = (state == REQ) & mem_ack;
  assign count_next = count + CW'(push) - CW'(pop);
  assign Empty      = count == '0;
  assign mem_req    = state == REQ;
  assign mem_adr    = {adr_q[head], 2'b00};
  assign mem_wdata  = dat_q[head];
  assign mem_radr   = DataAdr;
  assign ReadData   = (!MemWrite && hit) ? fwd_data : mem_rdata;
  // scan oldest to youngest so the last live match (the youngest) wins
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (CW'(k) < count && adr_q[idx] == DataAdr[31:2]) begin
        hit = 1'b1;
        fwd_data = dat_q[idx];
      end
    end
  end
  // pointers, occupancy and drain state; a pop leaves REQ only when the buffer empties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      count <= count_next;
      state <= (state == REQ) ? ((count_next == '0) ? IDLE : REQ) : ((count != '0) ? REQ : IDLE);
    end
  end
  // entry storage is unreset; liveness comes from head/count alone
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail] <= DataAdr[31:2];
      dat_q[tail] <= WriteData;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of push, stall, drain order, forwarding and reset
module tb_store_buffer;
  logic clk = 0, reset = 0, MemWrite = 0, mem_ack = 0;
  logic [31:0] DataAdr = 0, WriteData = 0, mem_rdata = 32'hDEADBEEF;
  logic [31:0] ReadData, mem_adr, mem_wdata, mem_radr;
  logic Stall, Empty, mem_req;
  int checks = 0, errors = 0;
  logic [31:0] qa[$], qd[$];
  logic [31:0] ha, hd;
  logic hold;
  int pushed, got;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .Empty(Empty),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_radr(mem_radr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1;
    DataAdr = a;
    WriteData = d;
  endtask

  initial begin
    #1 reset = 1;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_empty", Empty, 1);
    MemWrite = 1;
    #1;
    chk("rst_stall", Stall, 0);
    MemWrite = 0;
    @(posedge clk);
    #1 reset = 0;
    // single store, ack tied high
    mem_ack = 1;
    st(20, 2);
    #1;
    chk("s1_stall", Stall, 0);
    chk("s1_empty0", Empty, 1);
    tick;
    MemWrite = 0;
    #1;
    chk("s1_req0", mem_req, 0);
    chk("s1_empty1", Empty, 0);
    chk("s1_fwd", ReadData, 2);
    chk("s1_radr", mem_radr, 20);
    tick;
    #1;
    chk("s1_req1", mem_req, 1);
    chk("s1_adr", mem_adr, 20);
    chk("s1_wdata", mem_wdata, 2);
    chk("s1_fwd_pop", ReadData, 2);
    tick;
    #1;
    chk("s1_empty2", Empty, 1);
    chk("s1_req2", mem_req, 0);
    chk("s1_nofwd", ReadData, 32'hDEADBEEF);
    // fill to full, then stall
    mem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      st(32'(i) * 4, 100 + 32'(i));
      #1;
      chk("fill_stall", Stall, 0);
      tick;
    end
    st(16, 104);
    #1;
    chk("full_stall", Stall, 1);
    chk("full_req", mem_req, 1);
    chk("full_adr", mem_adr, 0);
    chk("full_wdata", mem_wdata, 100);
    tick;
    #1;
    chk("hold_adr", mem_adr, 0);
    chk("hold_wdata", mem_wdata, 100);
    mem_ack = 1;
    #1;
    chk("pop_stall_same", Stall, 1);
    tick;
    mem_ack = 0;
    #1;
    chk("pop_stall_next", Stall, 0);
    chk("pop_adr_next", mem_adr, 4);
    tick;
    DataAdr = 20;
    #1;
    chk("push16_full", Stall, 1);
    MemWrite = 0;
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_drain_adr", mem_adr, 4 * (32'(i) + 1));
      chk("fill_drain_wdata", mem_wdata, 101 + 32'(i));
      chk("fill_drain_req", mem_req, 1);
      tick;
    end
    #1;
    chk("fill_empty", Empty, 1);
    chk("fill_req_off", mem_req, 0);
    // forwarding and same-address ordering
    mem_ack = 0;
    st(32'h41, 32'h11);
    tick;
    st(32'h40, 32'h22);
    tick;
    MemWrite = 0;
    DataAdr = 32'h40;
    #1;
    chk("fwd_young", ReadData, 32'h22);
    DataAdr = 32'h43;
    #1;
    chk("fwd_lowbits", ReadData, 32'h22);
    DataAdr = 32'h44;
    #1;
    chk("fwd_miss", ReadData, 32'hDEADBEEF);
    chk("fwd_radr", mem_radr, 32'h44);
    DataAdr = 32'h40;
    mem_ack = 1;
    #1;
    chk("same_adr0", mem_adr, 32'h40);
    chk("same_wdata0", mem_wdata, 32'h11);
    tick;
    #1;
    chk("same_adr1", mem_adr, 32'h40);
    chk("same_wdata1", mem_wdata, 32'h22);
    chk("fwd_popping", ReadData, 32'h22);
    tick;
    #1;
    chk("same_empty", Empty, 1);
    chk("fwd_gone", ReadData, 32'hDEADBEEF);
    // simultaneous push and pop at count 2
    mem_ack = 0;
    st(32'h100, 1);
    tick;
    st(32'h104, 2);
    tick;
    st(32'h108, 3);
    mem_ack = 1;
    #1;
    chk("sim_head", mem_wdata, 1);
    chk("sim_stall", Stall, 0);
    tick;
    mem_ack = 0;
    st(32'h10C, 4);
    #1;
    chk("sim_c2_stall", Stall, 0);
    chk("sim_next", mem_wdata, 2);
    tick;
    st(32'h110, 5);
    #1;
    chk("sim_c3_stall", Stall, 0);
    tick;
    st(32'h114, 6);
    #1;
    chk("sim_c4_stall", Stall, 1);
    MemWrite = 0;
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sim_drain_wdata", mem_wdata, 2 + 32'(i));
      chk("sim_drain_adr", mem_adr, 32'h104 + 4 * 32'(i));
      tick;
    end
    #1;
    chk("sim_empty", Empty, 1);
    // ten stores with random ack gaps against a queue model
    pushed = 0;
    got = 0;
    hold = 0;
    for (int c = 0; c < 400 && got < 10; c++) begin
      MemWrite = pushed < 10;
      DataAdr = 32'h200 + 32'(pushed) * 4;
      WriteData = 32'h5000 + 32'(pushed);
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_stall", Stall, 32'(MemWrite && qa.size() == 4));
      if (hold) begin
        chk("rnd_hold_adr", mem_adr, ha);
        chk("rnd_hold_wdata", mem_wdata, hd);
      end
      if (mem_req && mem_ack) begin
        chk("rnd_adr", mem_adr, qa.size() > 0 ? qa[0] : 32'hFFFFFFFF);
        chk("rnd_wdata", mem_wdata, qd.size() > 0 ? qd[0] : 32'hFFFFFFFF);
        if (qa.size() > 0) begin
          void'(qa.pop_front());
          void'(qd.pop_front());
        end
        got++;
      end
      hold = mem_req && !mem_ack;
      ha = mem_adr;
      hd = mem_wdata;
      if (MemWrite && !Stall) begin
        qa.push_back(DataAdr);
        qd.push_back(WriteData);
        pushed++;
      end
      tick;
    end
    MemWrite = 0;
    mem_ack = 0;
    #1;
    chk("rnd_got", got, 10);
    chk("rnd_empty", Empty, 1);
    // reset mid-drain discards everything
    for (int i = 0; i < 3; i++) begin
      st(32'h80 + 32'(i) * 4, 32'hA0 + 32'(i));
      tick;
    end
    MemWrite = 0;
    #1;
    chk("mid_req", mem_req, 1);
    chk("mid_empty", Empty, 0);
    #2 reset = 1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_empty", Empty, 1);
    tick;
    reset = 0;
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_req", mem_req, 0);
      chk("post_rst_empty", Empty, 1);
      tick;
    end
    // first push right after reset release
    reset = 1;
    tick;
    reset = 0;
    st(32'h300, 7);
    tick;
    MemWrite = 0;
    #1;
    chk("first_push", Empty, 0);
    tick;
    #1;
    chk("first_req", mem_req, 1);
    chk("first_adr", mem_adr, 32'h300);
    chk("first_wdata", mem_wdata, 7);
    tick;
    #1;
    chk("first_done", Empty, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
